// File: rtl/uart_mmap_master_if.sv
// ----------------------------------------------------------------------------
// uart_mmap_master_if
//
// Bundles the three streams around the UART-to-memory-mapped bridge:
//   rx stream : rx_data[7:0], rx_valid (to bridge), rx_ready (from bridge)
//   tx stream : tx_data[7:0], tx_valid (from bridge), tx_ready (to bridge)
//   mm bus    : mm_en, mm_addr[15:0], mm_sel[2:0], mm_wdata[31:0] (from bridge)
//               mm_rdata[31:0] (to bridge, registered by the responder)
//
// Modports:
//   master : the bridge side (drives rx_ready, tx_*, mm_* requests)
//   slave  : the environment side (UART + memory-mapped responder)
// ----------------------------------------------------------------------------
interface uart_mmap_master_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  logic        mm_en;
  logic [15:0] mm_addr;
  logic [2:0]  mm_sel;
  logic [31:0] mm_wdata;
  logic [31:0] mm_rdata;

  modport master (
    input  rx_data, rx_valid, tx_ready, mm_rdata,
    output rx_ready, tx_data, tx_valid, mm_en, mm_addr, mm_sel, mm_wdata
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, mm_rdata,
    input  rx_ready, tx_data, tx_valid, mm_en, mm_addr, mm_sel, mm_wdata
  );
endinterface

// File: rtl/uart_mmap_master.sv
// ----------------------------------------------------------------------------
// uart_mmap_master
//
// Command-driven initiator for the memory-mapped bus. Framed byte commands
// arrive on the UART receive stream, each frame issues one load or store on
// the bus, and the result (load data, store ACK, or NAK for a bad opcode) is
// returned on the UART transmit stream.
//
// Frames:  'L' (0x4C) addr_hi addr_lo                    -> 4 data bytes, MSB first
//          'S' (0x53) addr_hi addr_lo d3 d2 d1 d0        -> 0x06
//          any other opcode                              -> 0x15
//
// Ports:
//   clk   : single clock, rising edge
//   rst   : asynchronous, active-low reset
//   bus   : uart_mmap_master_if.master (rx stream, tx stream, mm bus)
//   busy  : high whenever the bridge is not idle
//
// Parameters:
//   TIMEOUT_CYCLES : inter-byte timeout in clk cycles (timeout feature only)
//
// Build option:
//   MMAP_BRIDGE_TIMEOUT_EN : when defined, a frame that stalls for
//   TIMEOUT_CYCLES between bytes is discarded and answered with NAK.
//   When undefined the bridge waits indefinitely for the next frame byte.
// ----------------------------------------------------------------------------
module uart_mmap_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1_250_000
) (
  input  logic                      clk,
  input  logic                      rst,
  uart_mmap_master_if.master        bus,
  output logic                      busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_DATA,
    S_ISSUE,
    S_WAIT_RD,
    S_SEND,
    S_NAK
  } state_e;

  localparam logic [7:0] OP_LOAD   = 8'h4C;
  localparam logic [7:0] OP_STORE  = 8'h53;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  localparam logic [2:0] SEL_LOAD  = 3'd1;
  localparam logic [2:0] SEL_STORE = 3'd2;
  localparam logic [2:0] SEL_IDLE  = 3'd6;

  // A zero timeout would fire before the first stall cycle.
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("uart_mmap_master: TIMEOUT_CYCLES must be at least 1");
  end

  state_e      state_q,     state_d;
  logic        is_store_q,  is_store_d;
  logic [15:0] addr_asm_q,  addr_asm_d;   // address being assembled
  logic [23:0] wdata_asm_q, wdata_asm_d;  // first three store data bytes
  logic [15:0] mm_addr_q,   mm_addr_d;    // address presented on the bus
  logic [31:0] mm_wdata_q,  mm_wdata_d;   // store data presented on the bus
  logic [1:0]  data_cnt_q,  data_cnt_d;   // store data bytes received so far
  logic [1:0]  send_cnt_q,  send_cnt_d;   // response bytes remaining minus one
  logic [31:0] resp_q,      resp_d;       // response shift register, MSB out

  logic        rx_fire;
  logic        tx_fire;
  logic        opcode_ok;
  logic        timeout_hit;

  assign rx_fire   = bus.rx_valid && bus.rx_ready;
  assign tx_fire   = bus.tx_valid && bus.tx_ready;
  assign opcode_ok = (bus.rx_data == OP_LOAD) || (bus.rx_data == OP_STORE);

  // --------------------------------------------------------------------------
  // Optional inter-byte timeout
  // --------------------------------------------------------------------------
`ifdef MMAP_BRIDGE_TIMEOUT_EN
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        in_frame;

  assign in_frame    = state_q inside {S_ADDR_HI, S_ADDR_LO, S_DATA};
  // The counter holds the number of stall cycles already seen, so the
  // TIMEOUT_CYCLES-th consecutive stall cycle is the one that aborts.
  assign timeout_hit = in_frame && !rx_fire && (tmo_cnt_q == TIMEOUT_CYCLES - 1);

  always_comb begin
    tmo_cnt_d = '0;
    if (in_frame && !rx_fire && !timeout_hit) begin
      tmo_cnt_d = tmo_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: state is sampled with non-blocking assignments so every flop
      // sees the pre-edge values of the others, independent of block order.
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaulting to the current state keeps every path assigned, so no
    // latch is inferred for the branches that do not change state.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          state_d = opcode_ok ? S_ADDR_HI : S_NAK;
        end
      end
      S_ADDR_HI: begin
        if (rx_fire)          state_d = S_ADDR_LO;
        else if (timeout_hit) state_d = S_NAK;
      end
      S_ADDR_LO: begin
        if (rx_fire)          state_d = is_store_q ? S_DATA : S_ISSUE;
        else if (timeout_hit) state_d = S_NAK;
      end
      S_DATA: begin
        if (rx_fire) begin
          if (data_cnt_q == 2'd3) state_d = S_ISSUE;
        end else if (timeout_hit) begin
          state_d = S_NAK;
        end
      end
      S_ISSUE: begin
        state_d = is_store_q ? S_SEND : S_WAIT_RD;
      end
      S_WAIT_RD: begin
        state_d = S_SEND;
      end
      S_SEND: begin
        if (tx_fire && (send_cnt_q == 2'd0)) state_d = S_IDLE;
      end
      S_NAK: begin
        if (tx_fire) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath next-value logic
  // --------------------------------------------------------------------------
  always_comb begin
    is_store_d  = is_store_q;
    addr_asm_d  = addr_asm_q;
    wdata_asm_d = wdata_asm_q;
    mm_addr_d   = mm_addr_q;
    mm_wdata_d  = mm_wdata_q;
    data_cnt_d  = data_cnt_q;
    send_cnt_d  = send_cnt_q;
    resp_d      = resp_q;

    unique case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          is_store_d = (bus.rx_data == OP_STORE);
          if (!opcode_ok) resp_d = {RSP_NAK, 24'h0};
        end
      end
      S_ADDR_HI: begin
        if (rx_fire) addr_asm_d[15:8] = bus.rx_data;
      end
      S_ADDR_LO: begin
        if (rx_fire) begin
          addr_asm_d[7:0] = bus.rx_data;
          data_cnt_d      = 2'd0;
          // A load issues next cycle, so its address goes straight to the bus.
          if (!is_store_q) mm_addr_d = {addr_asm_q[15:8], bus.rx_data};
        end
      end
      S_DATA: begin
        if (rx_fire) begin
          data_cnt_d  = data_cnt_q + 2'd1;
          wdata_asm_d = {wdata_asm_q[15:0], bus.rx_data};
          // The bus registers only change once the whole frame is in, so they
          // keep the previous transaction's values while a store assembles.
          if (data_cnt_q == 2'd3) begin
            mm_addr_d  = addr_asm_q;
            mm_wdata_d = {wdata_asm_q, bus.rx_data};
          end
        end
      end
      S_ISSUE: begin
        if (is_store_q) begin
          resp_d     = {RSP_ACK, 24'h0};
          send_cnt_d = 2'd0;
        end
      end
      S_WAIT_RD: begin
        // The responder's registered load data is valid in this cycle.
        resp_d     = bus.mm_rdata;
        send_cnt_d = 2'd3;
      end
      S_SEND: begin
        if (tx_fire) begin
          resp_d     = {resp_q[23:0], 8'h00};
          send_cnt_d = send_cnt_q - 2'd1;
        end
      end
      S_NAK: begin
        resp_d = resp_q;
      end
      default: begin
        resp_d = resp_q;
      end
    endcase

    if (timeout_hit) resp_d = {RSP_NAK, 24'h0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_store_q  <= 1'b0;
      addr_asm_q  <= '0;
      wdata_asm_q <= '0;
      mm_addr_q   <= '0;
      mm_wdata_q  <= '0;
      data_cnt_q  <= '0;
      send_cnt_q  <= '0;
      // NOTE: the response register is reset so tx_data comes out of reset
      // as 0; it is a plain register, not a memory array.
      resp_q      <= '0;
    end else begin
      is_store_q  <= is_store_d;
      addr_asm_q  <= addr_asm_d;
      wdata_asm_q <= wdata_asm_d;
      mm_addr_q   <= mm_addr_d;
      mm_wdata_q  <= mm_wdata_d;
      data_cnt_q  <= data_cnt_d;
      send_cnt_q  <= send_cnt_d;
      resp_q      <= resp_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    bus.rx_ready = 1'b0;
    bus.tx_valid = 1'b0;
    bus.mm_en    = 1'b0;
    bus.mm_sel   = SEL_IDLE;
    busy         = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE, S_ADDR_HI, S_ADDR_LO, S_DATA: begin
        bus.rx_ready = 1'b1;
      end
      S_ISSUE: begin
        // Decoded straight from the state flop, so reset kills the pulse
        // immediately.
        bus.mm_en  = 1'b1;
        bus.mm_sel = is_store_q ? SEL_STORE : SEL_LOAD;
      end
      S_SEND, S_NAK: begin
        bus.tx_valid = 1'b1;
      end
      default: begin
        bus.rx_ready = 1'b0;
      end
    endcase
  end

  assign bus.tx_data  = resp_q[31:24];
  assign bus.mm_addr  = mm_addr_q;
  assign bus.mm_wdata = mm_wdata_q;

endmodule

// File: tb/tb_uart_mmap_master.sv
`timescale 1ns/1ps
module tb_uart_mmap_master;

  localparam int unsigned TMO = 100;

  typedef enum int {K_LOAD, K_STORE, K_BAD} kind_e;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  always #5 clk = ~clk;

  uart_mmap_master_if bus ();

  uart_mmap_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.master),
    .busy (busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Word the responder returns for an address that was never stored.
  function automatic logic [31:0] default_word(input logic [15:0] a);
    if (a == 16'h0010) return 32'h1234_5678;
    return {a ^ 16'hA5C3, ~a};
  endfunction

  // --------------------------------------------------------------------------
  // Responder + monitor (environment side; bookkeeping only)
  // --------------------------------------------------------------------------
  bit [31:0]   resp_mem [bit [15:0]];
  int unsigned cyc = 0;
  int unsigned last_rx_cyc = 0;
  int unsigned en_cyc = 0;
  int unsigned en_cnt = 0;
  logic [2:0]  en_sel;
  logic [15:0] en_addr;
  logic [31:0] en_wdata;
  byte unsigned tx_q[$];
  int unsigned  tx_cyc_q[$];
  int unsigned hold_bad = 0;
  int unsigned rx_busy_bad = 0;
  int unsigned sel_bad = 0;
  logic        held_pending = 1'b0;
  logic [7:0]  held_data = 8'h00;

  initial bus.mm_rdata = 32'h0;

  always @(posedge clk) begin
    cyc++;
    if (held_pending && !(bus.tx_valid && bus.tx_data == held_data)) hold_bad++;
    held_pending = rst && bus.tx_valid && !bus.tx_ready;
    held_data    = bus.tx_data;
    if (bus.rx_valid && bus.rx_ready) last_rx_cyc = cyc;
    if (bus.tx_valid && bus.rx_ready) rx_busy_bad++;
    if (!bus.mm_en && bus.mm_sel != 3'd6) sel_bad++;
    if (bus.tx_valid && bus.tx_ready) begin
      tx_q.push_back(bus.tx_data);
      tx_cyc_q.push_back(cyc);
    end
    if (bus.mm_en) begin
      en_cnt++;
      en_cyc   = cyc;
      en_sel   = bus.mm_sel;
      en_addr  = bus.mm_addr;
      en_wdata = bus.mm_wdata;
      if (bus.mm_sel == 3'd1) begin
        bus.mm_rdata <= resp_mem.exists(bus.mm_addr) ? resp_mem[bus.mm_addr]
                                                     : default_word(bus.mm_addr);
      end else if (bus.mm_sel == 3'd2) begin
        resp_mem[bus.mm_addr] = bus.mm_wdata;
      end
    end
  end

  // tx_ready driver: 0 = always ready, 1 = 10 idle cycles per byte, 2 = random
  int bp_mode = 0;
  int bp_cnt  = 0;
  always @(negedge clk) begin
    if (bp_mode == 0) begin
      bus.tx_ready = 1'b1;
    end else if (bp_mode == 2) begin
      bus.tx_ready = 1'($urandom_range(0, 1));
    end else if (bus.tx_valid) begin
      if (bp_cnt == 10) begin
        bus.tx_ready = 1'b1;
        bp_cnt = 0;
      end else begin
        bus.tx_ready = 1'b0;
        bp_cnt++;
      end
    end else begin
      bus.tx_ready = 1'b0;
      bp_cnt = 0;
    end
  end

  // --------------------------------------------------------------------------
  // Reference model: memory contents plus expected transaction outcome
  // --------------------------------------------------------------------------
  bit [31:0]    model_mem [bit [15:0]];
  byte unsigned exp_q[$];
  int unsigned  tx_base = 0;
  int unsigned  en_base = 0;
  int unsigned  en_exp = 0;
  int unsigned  last_start = 0;
  kind_e        last_kind = K_BAD;
  logic [2:0]   exp_sel;
  logic [15:0]  exp_addr;
  logic [31:0]  exp_wdata;

  function automatic logic [31:0] model_read(input logic [15:0] a);
    return model_mem.exists(a) ? model_mem[a] : default_word(a);
  endfunction

  task automatic start_txn();
    exp_q.delete();
    tx_base = tx_q.size();
    en_base = en_cnt;
    en_exp  = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (!bus.rx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("rx_accept", 32'(bus.rx_ready), 32'd1);
    @(posedge clk);
  endtask

  task automatic push_frame(input kind_e k, input logic [15:0] a,
                            input logic [31:0] d, input logic [7:0] bad_op);
    logic [31:0] w;
    last_start = exp_q.size();
    last_kind  = k;
    case (k)
      K_LOAD: begin
        w = model_read(a);
        for (int i = 3; i >= 0; i--) exp_q.push_back(8'(w >> (8 * i)));
        en_exp++;
        exp_sel  = 3'd1;
        exp_addr = a;
        send_byte(8'h4C);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
      end
      K_STORE: begin
        model_mem[a] = d;
        exp_q.push_back(8'h06);
        en_exp++;
        exp_sel   = 3'd2;
        exp_addr  = a;
        exp_wdata = d;
        send_byte(8'h53);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        for (int i = 3; i >= 0; i--) send_byte(8'(d >> (8 * i)));
      end
      default: begin
        exp_q.push_back(8'h15);
        send_byte(bad_op);
      end
    endcase
  endtask

  task automatic finish_and_check(input string name, input bit lat);
    int n = 0;
    int unsigned idx;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    while ((busy || (tx_q.size() - tx_base) < exp_q.size()) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, 32'(busy), 32'd0);
    check({name, "_ntx"}, 32'(tx_q.size() - tx_base), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      idx = tx_base + i;
      check($sformatf("%s_byte%0d", name, i),
            (idx < tx_q.size()) ? 32'(tx_q[idx]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    end
    check({name, "_en_count"}, en_cnt - en_base, en_exp);
    if (last_kind != K_BAD) begin
      check({name, "_sel"}, 32'(en_sel), 32'(exp_sel));
      check({name, "_addr"}, 32'(en_addr), 32'(exp_addr));
      if (last_kind == K_STORE) check({name, "_wdata"}, en_wdata, exp_wdata);
    end
    if (lat) begin
      idx = tx_base + last_start;
      if (last_kind != K_BAD) check({name, "_lat_en"}, en_cyc - last_rx_cyc, 32'd1);
      check({name, "_lat_tx"},
            (idx < tx_cyc_q.size()) ? tx_cyc_q[idx] - last_rx_cyc : 32'hFFFF_FFFF,
            (last_kind == K_LOAD) ? 32'd3 : (last_kind == K_STORE) ? 32'd2 : 32'd1);
      if (last_kind == K_LOAD)
        check({name, "_burst"},
              (idx + 3 < tx_cyc_q.size()) ? tx_cyc_q[idx + 3] - tx_cyc_q[idx] : 32'hFFFF_FFFF,
              32'd3);
    end
    check({name, "_rx_ready"}, 32'(bus.rx_ready), 32'd1);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_rx_ready"}, 32'(bus.rx_ready), 32'd1);
    check({name, "_tx_valid"}, 32'(bus.tx_valid), 32'd0);
    check({name, "_tx_data"},  32'(bus.tx_data),  32'd0);
    check({name, "_mm_en"},    32'(bus.mm_en),    32'd0);
    check({name, "_mm_sel"},   32'(bus.mm_sel),   32'd6);
    check({name, "_mm_addr"},  32'(bus.mm_addr),  32'd0);
    check({name, "_mm_wdata"}, bus.mm_wdata,      32'd0);
    check({name, "_busy"},     32'(busy),         32'd0);
  endtask

  // --------------------------------------------------------------------------
  // Directed + randomized sequence
  // --------------------------------------------------------------------------
  initial begin
    kind_e       k;
    logic [15:0] a;
    logic [31:0] d;
    logic [7:0]  b;
    logic [31:0] w;

    rst          = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("post_reset");

    // Load from 0x0010 (responder returns 0x1234_5678)
    start_txn();
    push_frame(K_LOAD, 16'h0010, 32'h0, 8'h00);
    finish_and_check("load_0010", 1'b1);

    // Store 0x2A to 0x0030, then read it back
    start_txn();
    push_frame(K_STORE, 16'h0030, 32'h0000_002A, 8'h00);
    finish_and_check("store_0030", 1'b1);
    start_txn();
    push_frame(K_LOAD, 16'h0030, 32'h0, 8'h00);
    finish_and_check("readback_0030", 1'b1);

    // Bad opcode, immediately followed by a load held off by rx_ready=0
    start_txn();
    push_frame(K_BAD, 16'h0, 32'h0, 8'h58);
    check("bad_lat_tx_first", tx_q.size() - tx_base, 32'd0);
    push_frame(K_LOAD, 16'h0010, 32'h0, 8'h00);
    finish_and_check("bad_then_load", 1'b1);

    // Backpressure: 10 idle cycles per response byte
    bp_mode = 1;
    start_txn();
    push_frame(K_LOAD, 16'h0010, 32'h0, 8'h00);
    finish_and_check("bp_load", 1'b0);
    bp_mode = 0;
    repeat (2) @(negedge clk);

    // Reset after the second store data byte
    start_txn();
    send_byte(8'h53);
    send_byte(8'h00);
    send_byte(8'h34);
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(negedge clk);
    rst          = 1'b0;
    bus.rx_valid = 1'b0;
    #1;
    check_reset_values("mid_reset");
    repeat (5) @(negedge clk);
    check("mid_reset_no_en", en_cnt - en_base, 32'd0);
    check("mid_reset_no_tx", tx_q.size() - tx_base, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    start_txn();
    push_frame(K_STORE, 16'h0034, 32'hC0DE_0077, 8'h00);
    finish_and_check("store_0034", 1'b1);
    start_txn();
    push_frame(K_LOAD, 16'h0034, 32'h0, 8'h00);
    finish_and_check("readback_0034", 1'b1);

    // Randomized frames over a small address window so loads hit stores
    for (int t = 0; t < 24; t++) begin
      bp_mode = (t % 3 == 2) ? 2 : 0;
      k = kind_e'($urandom_range(0, 2));
      a = 16'h0100 + 16'($urandom_range(0, 7)) * 16'd4;
      d = $urandom;
      do b = 8'($urandom); while (b == 8'h4C || b == 8'h53);
      start_txn();
      push_frame(k, a, d, b);
      finish_and_check($sformatf("rand%0d", t), bp_mode == 0);
    end
    bp_mode = 0;
    repeat (2) @(negedge clk);

`ifdef MMAP_BRIDGE_TIMEOUT_EN
    // Partial load then a long stall: frame discarded, NAK, no bus access
    start_txn();
    last_kind  = K_BAD;
    last_start = 0;
    exp_q.push_back(8'h15);
    send_byte(8'h4C);
    send_byte(8'h00);
    finish_and_check("timeout", 1'b0);
    check("timeout_window",
          (tx_base < tx_cyc_q.size()) &&
          (tx_cyc_q[tx_base] - last_rx_cyc >= TMO) &&
          (tx_cyc_q[tx_base] - last_rx_cyc <= TMO + 2) ? 32'd1 : 32'd0, 32'd1);
`else
    // Without the timeout the bridge waits through a long stall mid-frame
    start_txn();
    w = model_read(16'h0010);
    for (int i = 3; i >= 0; i--) exp_q.push_back(8'(w >> (8 * i)));
    en_exp     = 1;
    exp_sel    = 3'd1;
    exp_addr   = 16'h0010;
    last_kind  = K_LOAD;
    last_start = 0;
    send_byte(8'h4C);
    send_byte(8'h00);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (200) @(negedge clk);
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_no_tx", tx_q.size() - tx_base, 32'd0);
    send_byte(8'h10);
    finish_and_check("stall_load", 1'b1);
`endif

    // Follow-up frame after the stall scenario
    start_txn();
    push_frame(K_LOAD, 16'h0030, 32'h0, 8'h00);
    finish_and_check("after_stall", 1'b1);

    check("tx_hold_stable", hold_bad, 32'd0);
    check("rx_ready_while_tx", rx_busy_bad, 32'd0);
    check("idle_sel", sel_bad, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global bound so the run always ends
  initial begin
    #5_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/uart_mmap_master.md
# uart_mmap_master

Command-driven initiator for the memory-mapped I/O bus. It accepts framed byte commands from a UART receive stream and issues single load or store transactions toward the memory-mapped responder. Load results and store acknowledgements go back over a UART transmit stream. It sits between the on-chip UART and the memory-mapped peripheral block, giving a host PC debug access to every mapped register without CPU involvement.

## Interface
- `TIMEOUT_CYCLES`, default 1_250_000: inter-byte timeout in `clk` cycles. Only used when the timeout feature is compiled in.
- `clk` input 1: single clock; all logic is on its rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `rx_data` input 8: received byte.
- `rx_valid` input 1: `rx_data` is valid.
- `rx_ready` output 1: bridge accepts a byte this cycle.
- `tx_data` output 8: byte to transmit.
- `tx_valid` output 1: `tx_data` is valid.
- `tx_ready` input 1: transmitter accepts a byte this cycle.
- `mm_en` output 1: bus enable, one-cycle pulse per transaction.
- `mm_addr` output 16: bus address.
- `mm_sel` output 3: 3'd1 load, 3'd2 store, 3'd6 idle (no-op).
- `mm_wdata` output 32: store data.
- `mm_rdata` input 32: load data, registered by the responder, valid one cycle after the `mm_en` load pulse.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- Frame format:
  - Opcode byte: 0x4C ('L') for load, 0x53 ('S') for store.
  - Address high byte, then address low byte.
  - Store only: 4 data bytes, MSB first.
- A byte transfers on a cycle where `rx_valid && rx_ready` (or `tx_valid && tx_ready` for transmit).
- States and transitions:
  - IDLE: opcode 'L' or 'S' goes to ADDR_HI. Any other opcode goes to NAK.
  - ADDR_HI goes to ADDR_LO.
  - ADDR_LO goes to ISSUE for a load, or to DATA for a store.
  - DATA: 2-bit counter, 4 bytes, then ISSUE.
  - ISSUE: for a load, goes to WAIT_RD. For a store, goes to SEND with a 1-byte response.
  - WAIT_RD goes to SEND with a 4-byte response.
  - SEND: counter tracks remaining bytes; returns to IDLE after the final handshake.
  - NAK: sends one byte, then returns to IDLE.
- `rx_ready` is 1 only in IDLE, ADDR_HI, ADDR_LO and DATA.
- Data assembly:
  - `mm_addr` is the high byte concatenated with the low byte.
  - `mm_wdata` is shifted left by 8 per data byte, so the first data byte ends in bits 31:24.
- ISSUE: `mm_en` is 1 for exactly one cycle; `mm_sel` is 1 or 2; `mm_addr` and `mm_wdata` are stable.
- All other cycles: `mm_en`=0, `mm_sel`=3'd6. `mm_addr` and `mm_wdata` hold their last values.
- WAIT_RD captures `mm_rdata` into the response shift register.
- Responses:
  - Load: 4 bytes, MSB first.
  - Store: 0x06 (ACK).
  - Bad opcode: 0x15 (NAK).
- `tx_valid` stays high and `tx_data` stays stable until `tx_ready`. The next byte is presented on the cycle after a handshake.
- No new frame is accepted while a response is pending.

## Timing
- Reset values:
  - State IDLE.
  - `rx_ready`=1.
  - `tx_valid`=0, `tx_data`=0.
  - `mm_en`=0, `mm_sel`=3'd6, `mm_addr`=0, `mm_wdata`=0.
  - `busy`=0.
- Load: last address byte accepted at cycle N.
  - N+1: `mm_en`=1.
  - N+2: `mm_rdata` captured.
  - N+3: `tx_valid`=1 with bits 31:24.
- Store: last data byte accepted at N.
  - N+1: `mm_en`=1.
  - N+2: `tx_valid`=1 with 0x06.
- Bad opcode accepted at N: `tx_valid`=1 with 0x15 at N+1.
- With `tx_ready` tied high, a load response takes 4 consecutive cycles.
- `rx_valid` while `rx_ready`=0 is ignored; the upstream source holds the byte.
- Reset asserted mid-frame or mid-response:
  - Immediate return to reset values; partial frame discarded.
  - No `mm_en` pulse is issued after reset asserts.

## Configuration
- `MMAP_BRIDGE_TIMEOUT_EN` defined:
  - A counter runs in ADDR_HI, ADDR_LO and DATA and clears on every accepted byte.
  - Reaching `TIMEOUT_CYCLES` discards the frame and goes to NAK: sends 0x15, no bus transaction.
- Not defined: no counter; the bridge waits indefinitely for the next frame byte.

## Test plan
- Load: send 0x4C 0x00 0x10, with the responder returning 0x1234_5678 → one `mm_en` pulse, `mm_sel`=1, `mm_addr`=0x0010; tx bytes 0x12 0x34 0x56 0x78.
- Store: send 0x53 0x00 0x30 0x00 0x00 0x00 0x2A → one `mm_en` pulse, `mm_sel`=2, `mm_addr`=0x0030, `mm_wdata`=0x0000_002A; tx 0x06.
- Bad opcode 0x58 → tx 0x15, no `mm_en`; a following load frame works normally.
- Backpressure: load with `tx_ready` low for 10 cycles per byte → each byte held stable, order preserved, `rx_ready`=0 throughout.
- Reset after the second store data byte → outputs at reset values; a fresh store to 0x0034 then completes with the correct `mm_wdata`.
- With `MMAP_BRIDGE_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100: send 0x4C 0x00 then stall 100 cycles → tx 0x15, no `mm_en`, back in IDLE.
